// File: rtl/conbus_pkg.sv
// Shared definitions for the conbus decoder and the arbiter-level top.
package conbus_pkg;

  // Decoder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } conbus_state_e;

  // Default slave-field placement: top two address bits pick one of four slaves
  localparam int CONBUS_NSLV    = 4;
  localparam int CONBUS_SEL_MSB = 31;
  localparam int CONBUS_SEL_LSB = 30;
  localparam int CONBUS_TIMEOUT = 255;

  // True when a decoded slave index refers to an implemented slave port
  function automatic logic slot_mapped(input logic [31:0] slot, input int nslv);
    return int'(slot) < nslv;
  endfunction

endpackage

// File: rtl/conbus_wdog.sv
// Per-transfer watchdog: clear, count unacknowledged cycles, flag expiry.
// Saturates at TIMEOUT, so the counter never wraps.
module conbus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  // Count while asked to, holding at the expiry value
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr)
      cnt <= '0;
    else if (inc && !expired)
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/conbus_dec.sv
// Wishbone conbus slave decoder: routes one master beat to the slave picked
// by the upper address bits, returns its ack/data, and terminates unmapped
// or hung beats with a single-cycle error.
module conbus_dec
  import conbus_pkg::*;
#(
  parameter int NSLV    = CONBUS_NSLV,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_MSB = CONBUS_SEL_MSB,
  parameter int SEL_LSB = CONBUS_SEL_LSB,
  parameter int TIMEOUT = CONBUS_TIMEOUT
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  input  logic [DW/8-1:0]      m_sel_i,
  input  logic                 m_we_i,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  output logic [DW-1:0]        m_dat_o,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i
);

  localparam int SW = SEL_MSB - SEL_LSB + 1;

  conbus_state_e state, state_nxt;

  logic [SW-1:0]           slot_q;
  logic [SW-1:0]           adr_slot;
  logic                    req;
  logic                    mapped;
  logic [NSLV-1:0]         slv_oh;
  logic [NSLV-1:0][DW-1:0] s_dat_arr;
  logic [DW-1:0]           dat_sel;
  logic                    ack_sel;
  logic                    wd_clr;
  logic                    wd_inc;
  logic                    wd_expired;

  assign adr_slot  = m_adr_i[SEL_MSB:SEL_LSB];
  assign req       = m_cyc_i && m_stb_i;
  assign mapped    = slot_mapped(32'(adr_slot), NSLV);
  assign s_dat_arr = s_dat_i;

  // Broadcast signals are pure pass-through
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;

  // One-hot selection of the latched slave, only while a beat is in flight;
  // acks and data from any other port are masked off here
  for (genvar k = 0; k < NSLV; k++) begin : g_sel
    assign slv_oh[k] = (state == ST_ACTIVE) && (slot_q == SW'(k));
  end

  assign ack_sel = |(slv_oh & s_ack_i);

  // Read-data mux as AND-OR over the one-hot select (zero when nothing selected)
  always_comb begin
    dat_sel = '0;
    for (int k = 0; k < NSLV; k++)
      if (slv_oh[k]) dat_sel = dat_sel | s_dat_arr[k];
  end

  // Watchdog restarts on every entry to ACTIVE
  assign wd_clr = (state != ST_ACTIVE);
  assign wd_inc = (state == ST_ACTIVE) && !ack_sel;

  conbus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // State and slot registers; slot is captured only when a beat is accepted
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= ST_IDLE;
      slot_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req)
        slot_q <= adr_slot;
    end
  end

  // Next state: ack beats abort, abort beats timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (req) state_nxt = mapped ? ST_ACTIVE : ST_ERR;
      ST_ACTIVE:
        if (ack_sel)         state_nxt = ST_IDLE;
        else if (!m_cyc_i)   state_nxt = ST_IDLE;
        else if (wd_expired) state_nxt = ST_ERR;
      ST_ERR:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Master-side and per-slave outputs
  always_comb begin
    m_ack_o = ack_sel;
    m_dat_o = dat_sel;
    m_err_o = (state == ST_ERR);
    s_cyc_o = slv_oh & {NSLV{m_cyc_i}};
    s_stb_o = slv_oh & {NSLV{m_stb_i}};
  end

endmodule

// File: tb/tb_conbus_dec.sv
// Directed bench for conbus_dec: a 4-slave instance for the main scenarios and
// a 3-slave instance for the unmapped-address case, both with TIMEOUT=8.
module tb_conbus_dec;

  localparam int DW = 32;
  localparam int AW = 32;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [AW-1:0]   m_adr;
  logic [DW-1:0]   m_dat;
  logic [DW/8-1:0] m_sel;
  logic            m_we, m_cyc, m_stb;

  // 4-slave instance
  logic [DW-1:0]   m_dat_o;
  logic            m_ack_o, m_err_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_we_o;
  logic [3:0]      s_cyc_o, s_stb_o;
  logic [4*DW-1:0] s_dat;
  logic [3:0]      s_ack;

  // 3-slave instance
  logic [DW-1:0]   u_dat_o;
  logic            u_ack_o, u_err_o;
  logic [AW-1:0]   u_adr_o;
  logic [DW-1:0]   u_sdat_o;
  logic [DW/8-1:0] u_sel_o;
  logic            u_we_o;
  logic [2:0]      u_cyc_o, u_stb_o;
  logic [3*DW-1:0] u_sdat;
  logic [2:0]      u_ack;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  conbus_dec #(.NSLV(4), .AW(AW), .DW(DW), .SEL_MSB(31), .SEL_LSB(30), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat), .s_ack_i(s_ack)
  );

  conbus_dec #(.NSLV(3), .AW(AW), .DW(DW), .SEL_MSB(31), .SEL_LSB(30), .TIMEOUT(8)) dut_u (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(u_dat_o), .m_ack_o(u_ack_o), .m_err_o(u_err_o),
    .s_adr_o(u_adr_o), .s_dat_o(u_sdat_o), .s_sel_o(u_sel_o), .s_we_o(u_we_o),
    .s_cyc_o(u_cyc_o), .s_stb_o(u_stb_o), .s_dat_i(u_sdat), .s_ack_i(u_ack)
  );

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_bus(input int n);
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; s_ack = '0; u_ack = '0;
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    m_adr = 32'h8000_0000; m_dat = 32'hA5A5_5A5A; m_sel = 4'b1010; m_we = 1'b1;
    m_cyc = 1'b1; m_stb = 1'b1;
    s_ack = 4'b1111; u_ack = 3'b111;
    s_dat = {4{32'h1111_2222}}; u_sdat = {3{32'h3333_4444}};
    next_cyc(); next_cyc(); next_cyc();
    @(negedge sys_clk);
    checks++;
    if ({m_ack_o, m_err_o, s_cyc_o, s_stb_o} !== 10'b0 || m_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b err=%b cyc=%b stb=%b dat=%h, need all 0",
               m_ack_o, m_err_o, s_cyc_o, s_stb_o, m_dat_o);
    end
    checks++;
    if (s_adr_o !== 32'h8000_0000 || s_dat_o !== 32'hA5A5_5A5A || s_sel_o !== 4'b1010 || s_we_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_passthrough: adr=%h dat=%h sel=%b we=%b, need 80000000 a5a55a5a 1010 1",
               s_adr_o, s_dat_o, s_sel_o, s_we_o);
    end
    next_cyc();
    sys_rst = 1'b0;
    idle_bus(2);
  endtask

  task automatic test_zero_wait_read();
    // cycle 0
    m_adr = 32'h8000_0000; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    s_dat = '0; s_dat[2*DW +: DW] = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL zw_cycle0: stb=%b ack=%b, need 0000 0", s_stb_o, m_ack_o);
    end
    // cycle 1: slave 2 acks immediately
    next_cyc();
    s_ack = 4'b0100;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0100 || s_cyc_o !== 4'b0100 || m_ack_o !== 1'b1 || m_dat_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL zw_cycle1: stb=%b cyc=%b ack=%b dat=%h, need 0100 0100 1 deadbeef",
               s_stb_o, s_cyc_o, m_ack_o, m_dat_o);
    end
    // cycle 2: back in IDLE
    next_cyc();
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m_ack_o !== 1'b0 || m_dat_o !== 32'h0 || m_err_o !== 1'b0) begin
      errors++;
      $display("FAIL zw_cycle2: stb=%b ack=%b dat=%h err=%b, need 0000 0 0 0",
               s_stb_o, m_ack_o, m_dat_o, m_err_o);
    end
    idle_bus(2);
  endtask

  task automatic test_wait_write();
    bit bad;
    m_adr = 32'h4000_0010; m_dat = 32'h1234_5678; m_sel = 4'b0011; m_we = 1'b1;
    m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      s_ack = (c == 4) ? 4'b0010 : 4'b0000;
      @(negedge sys_clk);
      checks++;
      if (m_ack_o !== (c == 4) || m_err_o !== 1'b0 || s_stb_o !== 4'b0010) begin
        errors++;
        $display("FAIL ws_cycle%0d: ack=%b err=%b stb=%b, need %0d 0 0010",
                 c, m_ack_o, m_err_o, s_stb_o, (c == 4));
      end
      bad = (s_we_o !== 1'b1) || (s_dat_o !== 32'h1234_5678) || (s_sel_o !== 4'b0011) ||
            (s_adr_o !== 32'h4000_0010);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL ws_bcast%0d: we=%b dat=%h sel=%b adr=%h, need 1 12345678 0011 40000010",
                 c, s_we_o, s_dat_o, s_sel_o, s_adr_o);
      end
    end
    next_cyc();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; s_ack = '0;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ws_after: stb=%b ack=%b err=%b, need 0000 0 0", s_stb_o, m_ack_o, m_err_o);
    end
    idle_bus(2);
  endtask

  task automatic test_timeout();
    int err_cnt;
    err_cnt = 0;
    m_adr = 32'h0000_0000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      next_cyc();
      @(negedge sys_clk);
      checks++;
      if (m_err_o !== 1'b0 || s_stb_o !== 4'b0001) begin
        errors++;
        $display("FAIL to_wait%0d: err=%b stb=%b, need 0 0001", c, m_err_o, s_stb_o);
      end
    end
    next_cyc(); // cycle 10
    @(negedge sys_clk);
    checks++;
    if (m_err_o !== 1'b1 || s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000 || m_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL to_err: err=%b stb=%b cyc=%b ack=%b, need 1 0000 0000 0",
               m_err_o, s_stb_o, s_cyc_o, m_ack_o);
    end
    next_cyc(); // cycle 11, master drops
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (m_err_o !== 1'b0) begin
      errors++;
      $display("FAIL to_one_cycle: err=%b, need 0", m_err_o);
    end
    idle_bus(2);

    // ack arriving in the same cycle the counter hits TIMEOUT (cycle 9)
    m_adr = 32'h0000_0000; m_cyc = 1'b1; m_stb = 1'b1;
    s_dat = '0; s_dat[0 +: DW] = 32'h0BAD_F00D;
    for (int c = 1; c <= 9; c++) begin
      next_cyc();
      s_ack = (c == 9) ? 4'b0001 : 4'b0000;
      @(negedge sys_clk);
      if (m_err_o === 1'b1) err_cnt++;
    end
    checks++;
    if (m_ack_o !== 1'b1 || m_dat_o !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL to_ack_wins: ack=%b dat=%h, need 1 0badf00d", m_ack_o, m_dat_o);
    end
    next_cyc(); // cycle 10
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    @(negedge sys_clk);
    if (m_err_o === 1'b1) err_cnt++;
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL to_ack_no_err: err cycles=%0d, need 0", err_cnt);
    end
    idle_bus(2);
  endtask

  task automatic test_unmapped();
    m_adr = 32'hC000_0000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (u_cyc_o !== 3'b000 || u_err_o !== 1'b0) begin
      errors++;
      $display("FAIL um_cycle0: cyc=%b err=%b, need 000 0", u_cyc_o, u_err_o);
    end
    next_cyc(); // cycle 1
    @(negedge sys_clk);
    checks++;
    if (u_err_o !== 1'b1 || u_cyc_o !== 3'b000 || u_stb_o !== 3'b000 || u_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL um_cycle1: err=%b cyc=%b stb=%b ack=%b, need 1 000 000 0",
               u_err_o, u_cyc_o, u_stb_o, u_ack_o);
    end
    next_cyc(); // cycle 2
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (u_err_o !== 1'b0 || u_cyc_o !== 3'b000) begin
      errors++;
      $display("FAIL um_cycle2: err=%b cyc=%b, need 0 000", u_err_o, u_cyc_o);
    end
    idle_bus(2);
  endtask

  task automatic test_abort_stray();
    int bad_cnt;
    bad_cnt = 0;
    m_adr = 32'h4000_0000; m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      next_cyc();
      s_ack = 4'b0001; // spurious ack from unselected slave 0
      @(negedge sys_clk);
      if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o !== 4'b0010) bad_cnt++;
    end
    checks++;
    if (bad_cnt !== 0) begin
      errors++;
      $display("FAIL ab_stray: bad cycles=%0d, need 0", bad_cnt);
    end
    next_cyc(); // cycle 3: master abandons
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_cyc_o !== 4'b0000) begin
      errors++;
      $display("FAIL ab_cycle3: ack=%b err=%b cyc=%b, need 0 0 0000", m_ack_o, m_err_o, s_cyc_o);
    end
    next_cyc(); // cycle 4: IDLE; a request now is only strobed next cycle
    m_adr = 32'h4000_0000; m_cyc = 1'b1; m_stb = 1'b1; s_ack = 4'b0010;
    @(negedge sys_clk);
    checks++;
    if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      errors++;
      $display("FAIL ab_cycle4: ack=%b err=%b stb=%b, need 0 0 0000", m_ack_o, m_err_o, s_stb_o);
    end
    next_cyc(); // cycle 5: fresh beat completes normally
    @(negedge sys_clk);
    checks++;
    if (m_ack_o !== 1'b1 || s_stb_o !== 4'b0010) begin
      errors++;
      $display("FAIL ab_cycle5: ack=%b stb=%b, need 1 0010", m_ack_o, s_stb_o);
    end
    idle_bus(2);
  endtask

  task automatic test_back_to_back();
    s_dat = '0;
    s_dat[0 +: DW] = 32'h0000_AAAA;
    s_dat[3*DW +: DW] = 32'hCAFE_F00D;
    m_adr = 32'h0000_0004; m_cyc = 1'b1; m_stb = 1'b1;
    next_cyc(); // cycle 1
    s_ack = 4'b0001;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0001 || m_ack_o !== 1'b1 || m_dat_o !== 32'h0000_AAAA) begin
      errors++;
      $display("FAIL b2b_first: stb=%b ack=%b dat=%h, need 0001 1 0000aaaa", s_stb_o, m_ack_o, m_dat_o);
    end
    next_cyc(); // cycle 2: next beat sampled
    m_adr = 32'hC000_0008; s_ack = '0;
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0000 || m_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: stb=%b ack=%b, need 0000 0", s_stb_o, m_ack_o);
    end
    next_cyc(); // cycle 3
    s_ack = 4'b1001; // slave 0 ack is stray here
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b1000 || s_cyc_o !== 4'b1000 || m_ack_o !== 1'b1 || m_dat_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL b2b_second: stb=%b cyc=%b ack=%b dat=%h, need 1000 1000 1 cafef00d",
               s_stb_o, s_cyc_o, m_ack_o, m_dat_o);
    end
    idle_bus(2);
  endtask

  task automatic test_reset_mid();
    s_dat = '0; s_dat[2*DW +: DW] = 32'h5555_6666;
    m_adr = 32'h8000_0000; m_cyc = 1'b1; m_stb = 1'b1;
    next_cyc(); // cycle 1
    @(negedge sys_clk);
    checks++;
    if (s_stb_o !== 4'b0100) begin
      errors++;
      $display("FAIL rst_active: stb=%b, need 0100", s_stb_o);
    end
    next_cyc(); // cycle 2
    sys_rst = 1'b1;
    next_cyc(); // cycle 3, slave 2 now tries to ack
    s_ack = 4'b0100;
    @(negedge sys_clk);
    checks++;
    if ({m_ack_o, m_err_o, s_cyc_o, s_stb_o} !== 10'b0 || m_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: ack=%b err=%b cyc=%b stb=%b dat=%h, need all 0",
               m_ack_o, m_err_o, s_cyc_o, s_stb_o, m_dat_o);
    end
    next_cyc();
    sys_rst = 1'b0;
    idle_bus(2);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench exceeded time bound");
    $fatal(1, "time bound exceeded");
  end

  initial begin
    sys_rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_dat = '0; s_ack = '0; u_sdat = '0; u_ack = '0;
    next_cyc();
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_unmapped();
    test_abort_stray();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
